// File: rtl/if_fetch_controller_if.sv
// Instruction-memory request/response bundle between the fetch controller (master) and imem (slave).
// The request is held until the one-cycle ready strobe; rdata is valid only in that strobe cycle.
interface if_fetch_controller_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_controller.sv
// Fetch sequencer: owns the PC, runs the imem handshake, and loads IF/ID (1 instr/cycle on 0-wait imem).
// Stall parks a returned word in a skid register; a taken branch always wins and squashes in flight work.
module if_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_W    = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_stall,
    input  logic                     i_branch_taken,
    input  logic [31:0]              i_branch_target,
    if_fetch_controller_if.master    imem,
    output logic                     o_if_valid,
    output logic [31:0]              o_if_pc,
    output logic [31:0]              o_if_npc,
    output logic [31:0]              o_if_inst,
    output logic                     o_flush_out,
    output logic [NUM_W-1:0]         o_inst_num
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_addr;
    logic [31:0]        r_skid_dat;
    logic               r_if_valid;
    logic [31:0]        r_if_pc;
    logic [31:0]        r_if_npc;
    logic [31:0]        r_if_inst;
    logic               r_flush;
    logic [NUM_W-1:0]   r_inst_num;

    state_t             w_state_nxt;
    logic [31:0]        w_pc_nxt;
    logic               w_load;
    logic [31:0]        w_load_dat;
    logic               w_capture;
    logic               w_bubble;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_load_dat  = imem.rdata;
        w_capture   = 1'b0;
        w_bubble    = 1'b0;
        if (i_branch_taken) begin
            w_pc_nxt = i_branch_target;
            // An unanswered request cannot be withdrawn, so it is drained first.
            case (r_state)
                S_FETCH: w_state_nxt = imem.ready ? S_FETCH : S_DRAIN;
                S_DRAIN: w_state_nxt = S_DRAIN;
                default: w_state_nxt = S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_FETCH;
                S_FETCH: begin
                    if (imem.ready) begin
                        if (i_stall) begin
                            w_capture   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_load   = 1'b1;
                            w_pc_nxt = r_pc + 32'd1;
                        end
                    end else if (!i_stall) begin
                        w_bubble = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        w_load      = 1'b1;
                        w_load_dat  = r_skid_dat;
                        w_pc_nxt    = r_pc + 32'd1;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem.ready) w_state_nxt = S_FETCH;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_skid_dat <= 32'd0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_npc   <= 32'd0;
            r_if_inst  <= 32'd0;
            r_flush    <= 1'b0;
            r_inst_num <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flush <= i_branch_taken;
            // Every new request launches at the PC it will fetch; DRAIN keeps the abandoned one.
            if (w_state_nxt == S_FETCH) r_req_addr <= w_pc_nxt;
            if (w_capture) r_skid_dat <= imem.rdata;
            if (i_branch_taken) begin
                r_if_valid <= 1'b0;
                r_skid_dat <= 32'd0;
            end else if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_npc   <= r_pc + 32'd1;
                r_if_inst  <= w_load_dat;
                r_inst_num <= r_inst_num + 1'b1;
            end else if (w_bubble) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign imem.req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imem.addr   = r_req_addr;
    assign o_if_valid  = r_if_valid;
    assign o_if_pc     = r_if_pc;
    assign o_if_npc    = r_if_npc;
    assign o_if_inst   = r_if_inst;
    assign o_flush_out = r_flush;
    assign o_inst_num  = r_inst_num;

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller with a transaction-level reference model checked every cycle.
module tb_if_fetch_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        if_valid, flush_out;
    logic [31:0] if_pc, if_npc, if_inst;
    logic [3:0]  inst_num;

    if_fetch_controller_if imem_if();

    if_fetch_controller #(.RESET_PC(32'h0), .NUM_W(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_stall(stall),
        .i_branch_taken(br), .i_branch_target(tgt), .imem(imem_if.master),
        .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_npc(if_npc),
        .o_if_inst(if_inst), .o_flush_out(flush_out), .o_inst_num(inst_num)
    );

    int errors = 0;
    int checks = 0;
    int waits  = 0;
    int wcnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Reference model: tracks what fetch is doing in terms of outstanding work, not FSM states.
    bit          m_ok = 1'b0;
    bit          m_idle, m_held, m_drain, m_v, m_flush, m_fetching;
    logic [31:0] m_hdat, m_daddr, m_pc, m_ipc, m_inpc, m_iinst;
    int          m_cnt;

    task automatic m_deliver(input logic [31:0] dat);
        m_v     = 1'b1;
        m_ipc   = m_pc;
        m_inpc  = m_pc + 32'd1;
        m_iinst = dat;
        m_pc    = m_pc + 32'd1;
        m_cnt   = (m_cnt + 1) % 16;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_idle = 1'b1; m_held = 1'b0; m_drain = 1'b0; m_v = 1'b0;
            m_flush = 1'b0; m_hdat = 0; m_daddr = 0; m_pc = 0; m_ipc = 0; m_inpc = 0;
            m_iinst = 0; m_cnt = 0;
        end else if (m_ok) begin
            m_fetching = !m_idle && !m_held && !m_drain;
            m_flush = br;
            if (br) begin
                if (m_fetching && !imem_if.ready) begin
                    m_drain = 1'b1;
                    m_daddr = m_pc;
                end
                m_pc = tgt; m_v = 1'b0; m_held = 1'b0; m_idle = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_drain) begin
                if (imem_if.ready) m_drain = 1'b0;
            end else if (m_held) begin
                if (!stall) begin
                    m_deliver(m_hdat);
                    m_held = 1'b0;
                end
            end else if (imem_if.ready) begin
                if (stall) begin
                    m_held = 1'b1;
                    m_hdat = imem_if.rdata;
                end else begin
                    m_deliver(imem_if.rdata);
                end
            end else if (!stall) begin
                m_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("req", {31'd0, imem_if.req}, {31'd0, !m_idle && !m_held});
            chk("addr", imem_if.addr, m_drain ? m_daddr : m_pc);
            chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
            chk("if_pc", if_pc, m_ipc);
            chk("if_npc", if_npc, m_inpc);
            chk("if_inst", if_inst, m_iinst);
            chk("flush_out", {31'd0, flush_out}, {31'd0, m_flush});
            chk("inst_num", {28'd0, inst_num}, m_cnt[31:0]);
        end
    end

    // Memory responder: answers each request after `waits` idle request cycles.
    task automatic drive_mem();
        if (rst) begin
            imem_if.ready = 1'b0;
            imem_if.rdata = 32'h0BAD_0BAD;
            wcnt = 0;
        end else if (!imem_if.req) begin
            imem_if.ready = 1'b0;
            imem_if.rdata = 32'h0BAD_0BAD;
        end else if (wcnt >= waits) begin
            imem_if.ready = 1'b1;
            imem_if.rdata = memval(imem_if.addr);
            wcnt = 0;
        end else begin
            imem_if.ready = 1'b0;
            imem_if.rdata = 32'h0BAD_0BAD;
            wcnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        br = 1'b0;
        drive_mem();
    endtask

    task automatic run_until(input string name, input logic [31:0] a, input logic want_ready);
        int n = 0;
        while (!(imem_if.req && imem_if.addr == a && imem_if.ready == want_ready) && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL %s: timeout waiting for addr %h ready %0d", name, a, want_ready);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_req"}, {31'd0, imem_if.req}, 32'd0);
        chk({name, "_addr"}, imem_if.addr, 32'd0);
        chk({name, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({name, "_pc"}, if_pc, 32'd0);
        chk({name, "_npc"}, if_npc, 32'd0);
        chk({name, "_num"}, {28'd0, inst_num}, 32'd0);
        chk({name, "_flush"}, {31'd0, flush_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'd0;
        imem_if.ready = 1'b0; imem_if.rdata = 32'd0;
        step(); step();
        chk_reset_vals("reset");

        // 0-wait streaming
        rst = 1'b0;
        step();
        chk("t1_first_req", {31'd0, imem_if.req}, 32'd1);
        chk("t1_first_addr", imem_if.addr, 32'd0);
        step();
        chk("t1_pc0", if_pc, 32'd0);
        chk("t1_inst0", if_inst, 32'hDEAD_0000);
        chk("t1_num1", {28'd0, inst_num}, 32'd1);
        chk("t1_addr1", imem_if.addr, 32'd1);
        step();
        chk("t1_pc1", if_pc, 32'd1);
        chk("t1_num2", {28'd0, inst_num}, 32'd2);
        step();
        chk("t1_pc2", if_pc, 32'd2);
        chk("t1_num3", {28'd0, inst_num}, 32'd3);

        // 2-wait imem, 3-cycle stall on the response for addr 5
        waits = 2;
        run_until("t2_wait5", 32'd5, 1'b1);
        stall = 1'b1;
        step(); step(); step();
        chk("t2_hold_req", {31'd0, imem_if.req}, 32'd0);
        chk("t2_hold_pc", if_pc, 32'd4);
        stall = 1'b0;
        step();
        chk("t2_pc5", if_pc, 32'd5);
        chk("t2_inst5", if_inst, 32'hDEAD_0005);
        chk("t2_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_next_addr", imem_if.addr, 32'd6);

        // branch while addr 7 is outstanding
        run_until("t3_wait7", 32'd7, 1'b0);
        br = 1'b1; tgt = 32'h40;
        step();
        chk("t3_flush", {31'd0, flush_out}, 32'd1);
        chk("t3_drain_addr", imem_if.addr, 32'd7);
        chk("t3_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("t3_flush_off", {31'd0, flush_out}, 32'd0);
        run_until("t3_wait40", 32'h40, 1'b1);
        step();
        chk("t3_pc40", if_pc, 32'h40);
        chk("t3_inst40", if_inst, 32'hDEAD_0040);

        // branch coincident with ready and stall
        waits = 0;
        run_until("t4_wait42", 32'h42, 1'b1);
        stall = 1'b1; br = 1'b1; tgt = 32'h100;
        step();
        stall = 1'b0;
        chk("t4_req", {31'd0, imem_if.req}, 32'd1);
        chk("t4_addr", imem_if.addr, 32'h100);
        chk("t4_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("t4_pc100", if_pc, 32'h100);

        // inst_num wrap and PC wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (16) step();
        chk("t5_num15", {28'd0, inst_num}, 32'd15);
        step();
        chk("t5_num_wrap", {28'd0, inst_num}, 32'd0);
        chk("t5_pc15", if_pc, 32'd15);
        br = 1'b1; tgt = 32'hFFFF_FFFE;
        step(); step(); step();
        chk("t5_pc_max", if_pc, 32'hFFFF_FFFF);
        chk("t5_npc_wrap", if_npc, 32'd0);
        chk("t5_addr_wrap", imem_if.addr, 32'd0);

        // reset from HOLD
        stall = 1'b1;
        step();
        chk("t6_in_hold", {31'd0, imem_if.req}, 32'd0);
        rst = 1'b1;
        step();
        stall = 1'b0;
        chk_reset_vals("t6_hold");
        rst = 1'b0;
        step();
        chk("t6_restart", imem_if.addr, 32'd0);

        // reset from DRAIN
        waits = 3;
        step(); step();
        run_until("t6_pending", 32'd2, 1'b0);
        br = 1'b1; tgt = 32'h80;
        step();
        chk("t6_drain_addr", imem_if.addr, 32'd2);
        rst = 1'b1;
        step();
        chk_reset_vals("t6_drain");
        rst = 1'b0;
        repeat (6) step();
        chk("t6_drain_pc0", if_pc, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
